// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the opcode, extracts and extends the
// immediate for each instruction format, and registers value plus format code.
module imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm_result,
    output logic [2:0]      imm_type
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned TYP_W = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [TYP_W-1:0] TYPE_NONE  = 3'd0;
    localparam logic [TYP_W-1:0] TYPE_I     = 3'd1;
    localparam logic [TYP_W-1:0] TYPE_S     = 3'd2;
    localparam logic [TYP_W-1:0] TYPE_B     = 3'd3;
    localparam logic [TYP_W-1:0] TYPE_U     = 3'd4;
    localparam logic [TYP_W-1:0] TYPE_J     = 3'd5;
    localparam logic [TYP_W-1:0] TYPE_SHAMT = 3'd6;

    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;
    logic             sign;
    logic [XLEN-1:0]  imm_c;
    logic [TYP_W-1:0] type_c;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign sign   = instruction[31];

    // Format decode and immediate assembly; unknown opcodes yield zero/none.
    always_comb begin
        imm_c  = '0;
        type_c = TYPE_NONE;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm_c  = {{20{sign}}, instruction[31:20]};
                type_c = TYPE_I;
            end
            OPC_OP_IMM: begin
                // Shifts carry funct7 in [31:25]; only the 5-bit shamt is an operand.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_c  = {27'b0, instruction[24:20]};
                    type_c = TYPE_SHAMT;
                end else begin
                    imm_c  = {{20{sign}}, instruction[31:20]};
                    type_c = TYPE_I;
                end
            end
            OPC_STORE: begin
                imm_c  = {{20{sign}}, instruction[31:25], instruction[11:7]};
                type_c = TYPE_S;
            end
            OPC_BRANCH: begin
                imm_c  = {{19{sign}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
                type_c = TYPE_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c  = {instruction[31:12], 12'b0};
                type_c = TYPE_U;
            end
            OPC_JAL: begin
                imm_c  = {{11{sign}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
                type_c = TYPE_J;
            end
            default: begin
                imm_c  = '0;
                type_c = TYPE_NONE;
            end
        endcase
    end

    // Output register; reset wins over enable, en=0 stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_result <= '0;
            imm_type   <= TYPE_NONE;
        end else if (en) begin
            imm_result <= imm_c;
            imm_type   <= type_c;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen: vector table plus reset/stall sequences.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] instruction;
    logic [31:0] imm_result;
    logic [2:0]  imm_type;

    int errors = 0;
    int checks = 0;

    imm_gen #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .instruction (instruction),
        .imm_result  (imm_result),
        .imm_type    (imm_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] exp_imm;
        logic [2:0]  exp_type;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] exp_imm, input logic [2:0] exp_type);
        checks++;
        if (imm_result !== exp_imm) begin
            errors++;
            $display("FAIL %s imm: got %08h expected %08h", name, imm_result, exp_imm);
        end
        checks++;
        if (imm_type !== exp_type) begin
            errors++;
            $display("FAIL %s type: got %0d expected %0d", name, imm_type, exp_type);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [31:0] m, input logic [2:0] t);
        vec_t v;
        v.name = n; v.instr = i; v.exp_imm = m; v.exp_type = t;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk("addi_neg5",  32'hFFB10093, 32'hFFFFFFFB, 3'd1));
        vecs.push_back(mk("slli_31",    32'h01F11093, 32'h0000001F, 3'd6));
        vecs.push_back(mk("srai_31",    32'h41F15093, 32'h0000001F, 3'd6));
        vecs.push_back(mk("store_neg",  32'h80112423, 32'hFFFFF808, 3'd2));
        vecs.push_back(mk("sw_8",       32'h00112423, 32'h00000008, 3'd2));
        vecs.push_back(mk("branch_2",   32'h00208163, 32'h00000002, 3'd3));
        vecs.push_back(mk("beq_16",     32'h00208863, 32'h00000010, 3'd3));
        vecs.push_back(mk("branch_min", 32'h80000063, 32'hFFFFF000, 3'd3));
        vecs.push_back(mk("lui",        32'h123450B7, 32'h12345000, 3'd4));
        vecs.push_back(mk("auipc",      32'h00001097, 32'h00001000, 3'd4));
        vecs.push_back(mk("jal_min",    32'h800000EF, 32'hFFF00000, 3'd5));
        vecs.push_back(mk("jal_max",    32'h7FFFF0EF, 32'h000FFFFE, 3'd5));
        vecs.push_back(mk("jalr_8",     32'h008000E7, 32'h00000008, 3'd1));
        vecs.push_back(mk("system_m1",  32'hFFF00073, 32'hFFFFFFFF, 3'd1));
        vecs.push_back(mk("rtype_add",  32'h002081B3, 32'h00000000, 3'd0));
        vecs.push_back(mk("andi_7ff",   32'h7FF17093, 32'h000007FF, 3'd1));
        vecs.push_back(mk("lb_neg1",    32'hFFF10083, 32'hFFFFFFFF, 3'd1));

        // Reset held for two edges with a valid load on the bus.
        rst_n       = 1'b0;
        en          = 1'b1;
        instruction = 32'h00402083;
        step();
        step();
        check("reset", 32'h0, 3'd0);

        rst_n = 1'b1;
        step();
        check("lw_after_reset", 32'h00000004, 3'd1);

        foreach (vecs[k]) begin
            instruction = vecs[k].instr;
            en          = 1'b1;
            step();
            check(vecs[k].name, vecs[k].exp_imm, vecs[k].exp_type);
        end

        // Default opcode then stall: outputs must hold at zero until en returns.
        instruction = 32'h00000000;
        step();
        check("zero_word", 32'h0, 3'd0);
        en          = 1'b0;
        instruction = 32'hFFB10093;
        step();
        check("stall_1", 32'h0, 3'd0);
        step();
        check("stall_2", 32'h0, 3'd0);
        en = 1'b1;
        step();
        check("stall_release", 32'hFFFFFFFB, 3'd1);

        // Stall holds a nonzero value.
        en          = 1'b0;
        instruction = 32'h123450B7;
        step();
        check("stall_hold_nonzero", 32'hFFFFFFFB, 3'd1);

        // Reset overrides a stall.
        rst_n = 1'b0;
        step();
        check("reset_during_stall", 32'h0, 3'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("lui_after_reset", 32'h12345000, 3'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
